// File: rtl/moving_average_uart_tx.sv
// rtl/moving_average_uart_tx.sv - Buffers filtered samples and sends each one as two UART bytes
//
// Purpose:
//    Takes strobed DATA_IN_LEN-bit samples from the moving-average filter,
//    queues them in a small FIFO and serialises every sample as two bytes:
//       byte A = {1'b1, d[13:7]}   (bit 7 set marks the first byte)
//       byte B = {1'b0, d[6:0]}
//    The sample is zero-extended to 14 bits before the split. A is always
//    sent before B. The line format is 8N1, LSB first, each bit held for
//    CLKS_PER_BIT clocks. A sample is dropped if the FIFO is full, and
//    that drop sets a sticky overflow flag.
//
// Optional feature:
//    MOVING_AVERAGE_UART_PARITY_EN - when defined the frame becomes 8E1.
//    An even-parity bit over the 8 data bits is sent between the last data
//    bit and the stop bit.
//
// Ports:
//    clk           system clock, rising edge
//    rst_n         asynchronous active-low reset
//    data_in       filtered sample, qualified by strobe_in
//    strobe_in     sample-valid; one push per cycle while high
//    clr_overflow  synchronous clear of overflow (a same-cycle drop wins)
//    tx            UART line, idle high, driven from a flop
//    busy          high while a frame is in progress
//    overflow      sticky sample-dropped flag
//    fifo_level    number of samples currently stored

module moving_average_uart_tx #(
   parameter int DATA_IN_LEN  = 10,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_IN_LEN-1:0]        data_in,
   input  logic                          strobe_in,
   input  logic                          clr_overflow,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef MOVING_AVERAGE_UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Sample FIFO
   // ------------------------------------------------------------------
   logic [DATA_IN_LEN-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [LW-1:0]          level;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   push;
   logic                   pop;
   logic                   drop;

   // ------------------------------------------------------------------
   // Transmitter state
   // ------------------------------------------------------------------
   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic          baud_done;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_byte;
   logic [7:0]    byte_b_q;
   logic          byte_sel;
   logic [13:0]   head;
   logic [7:0]    byte_a;
   logic [7:0]    byte_b;

   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == FULL_LEVEL);
   assign fifo_level = level;

   // Zero-extend the head sample to 14 bits, then split it into the two bytes.
   assign head   = 14'(mem[rd_ptr]);
   assign byte_a = {1'b1, head[13:7]};
   assign byte_b = {1'b0, head[6:0]};

   always_comb begin
      baud_done = (baud_cnt == BAUD_LAST);
      pop       = 1'b0;
      if (!fifo_empty) begin
         if (state == S_IDLE) begin
            pop = 1'b1;
         end else if (state == S_STOP && baud_done && byte_sel) begin
            pop = 1'b1;
         end
      end
      // A pop in the same edge frees a slot, so a push into a full FIFO
      // is still accepted in that case.
      push = strobe_in && (!fifo_full || pop);
      drop = strobe_in && fifo_full && !pop;
   end

   // Storage needs no reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // UART framing FSM; tx and busy are registered here.
   // tx_byte is never shifted: bits are picked by bit_cnt so that the
   // whole byte remains available for the parity bit.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_byte  <= '0;
         byte_b_q <= '0;
         byte_sel <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  tx_byte  <= byte_a;
                  byte_b_q <= byte_b;
                  byte_sel <= 1'b0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_START;
               end
            end

            S_START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= tx_byte[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef MOVING_AVERAGE_UART_PARITY_EN
                     tx    <= ^tx_byte;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     tx      <= tx_byte[bit_cnt + 3'd1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

`ifdef MOVING_AVERAGE_UART_PARITY_EN
            S_PARITY: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
`endif

            S_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (!byte_sel) begin
                     // Byte B follows byte A with no idle gap.
                     tx_byte  <= byte_b_q;
                     byte_sel <= 1'b1;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else if (pop) begin
                     tx_byte  <= byte_a;
                     byte_b_q <= byte_b;
                     byte_sel <= 1'b0;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else begin
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end

            default: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               baud_cnt <= '0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moving_average_uart_tx.sv
// tb/tb_moving_average_uart_tx.sv - Self-checking bench for moving_average_uart_tx
module tb_moving_average_uart_tx;

   localparam int DW    = 10;
   localparam int C     = 4;
   localparam int DEPTH = 4;
   localparam int LVW   = $clog2(DEPTH) + 1;
`ifdef MOVING_AVERAGE_UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int SAMPLE_CYC = 2 * FRAME_BITS * C;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [DW-1:0]  data_in = '0;
   logic           strobe_in = 1'b0;
   logic           clr_overflow = 1'b0;
   logic           tx;
   logic           busy;
   logic           overflow;
   logic [LVW-1:0] fifo_level;

   int errors = 0;
   int checks = 0;
   int mon_err = 0;
   int reset_count = 0;

   logic [7:0] rx_q[$];
   logic       rx_par_q[$];
   logic [7:0] exp_q[$];

   moving_average_uart_tx #(
      .DATA_IN_LEN (DW),
      .CLKS_PER_BIT(C),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .strobe_in   (strobe_in),
      .clr_overflow(clr_overflow),
      .tx          (tx),
      .busy        (busy),
      .overflow    (overflow),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   always @(negedge rst_n) reset_count++;

   // Reference UART receiver: every bit must hold for exactly C cycles.
   initial begin : monitor
      int         rc;
      logic [7:0] b;
      logic       p;
      logic       v;
      logic       bad;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            rc  = reset_count;
            bad = 1'b0;
            b   = '0;
            p   = 1'b0;
            for (int i = 1; i < C; i++) begin
               @(negedge clk);
               if (tx !== 1'b0) bad = 1'b1;
            end
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               v    = tx;
               b[k] = v;
               for (int i = 1; i < C; i++) begin
                  @(negedge clk);
                  if (tx !== v) bad = 1'b1;
               end
            end
`ifdef MOVING_AVERAGE_UART_PARITY_EN
            @(negedge clk);
            p = tx;
            for (int i = 1; i < C; i++) begin
               @(negedge clk);
               if (tx !== p) bad = 1'b1;
            end
            if ((^b) !== p) bad = 1'b1;
`endif
            for (int i = 0; i < C; i++) begin
               @(negedge clk);
               if (tx !== 1'b1) bad = 1'b1;
            end
            if (reset_count == rc) begin
               if (bad) mon_err++;
               rx_q.push_back(b);
               rx_par_q.push_back(p);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void expect_sample(input int d);
      exp_q.push_back(8'(8'h80 | (d >> 7)));
      exp_q.push_back(8'(d & 8'h7F));
   endfunction

   task automatic clear_queues;
      rx_q.delete();
      rx_par_q.delete();
      exp_q.delete();
   endtask

   task automatic send(input int d);
      @(negedge clk);
      data_in   = DW'(d);
      strobe_in = 1'b1;
      @(posedge clk);
      #1;
      strobe_in = 1'b0;
   endtask

   task automatic pulse_clr;
      @(negedge clk);
      clr_overflow = 1'b1;
      @(posedge clk);
      #1;
      clr_overflow = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int g = 0; g < 20 * SAMPLE_CYC; g++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b0 && fifo_level === '0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2 * C) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx !== 1'b1)          begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (fifo_level !== '0)    begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      int n;
      bit ok;
      clear_queues();
      expect_sample(10'h2A5);
      send(10'h2A5);
      checks++; if (fifo_level !== LVW'(1)) begin errors++; $display("FAIL single_level_e0 got=%0d exp=1", fifo_level); end
      checks++; if (tx !== 1'b1)            begin errors++; $display("FAIL single_tx_e0 got=%b exp=1", tx); end
      @(posedge clk);
      #1;
      checks++; if (tx !== 1'b0)            begin errors++; $display("FAIL single_start_e1 got=%b exp=0", tx); end
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL single_busy_e1 got=%b exp=1", busy); end
      checks++; if (fifo_level !== '0)      begin errors++; $display("FAIL single_level_e1 got=%0d exp=0", fifo_level); end
      n = (busy === 1'b1) ? 1 : 0;
      for (int g = 0; g < 4 * SAMPLE_CYC && busy === 1'b1; g++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) n++;
      end
      checks++; if (n != SAMPLE_CYC) begin errors++; $display("FAIL single_busy_len got=%0d exp=%0d", n, SAMPLE_CYC); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_drain got=timeout exp=idle"); end
      checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL single_count got=%0d exp=2", rx_q.size()); end
      checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h85) begin errors++; $display("FAIL single_byte_a got=%h exp=85", rx_q[0]); end
      checks++; if (rx_q.size() > 1 && rx_q[1] !== 8'h25) begin errors++; $display("FAIL single_byte_b got=%h exp=25", rx_q[1]); end
`ifdef MOVING_AVERAGE_UART_PARITY_EN
      checks++; if (rx_par_q.size() != 2 || rx_par_q[0] !== 1'b1 || rx_par_q[1] !== 1'b1) begin
         errors++; $display("FAIL single_parity got_count=%0d exp=two bits of 1", rx_par_q.size());
      end
`endif
   endtask

   task automatic test_burst;
      int n;
      int exp_lvl;
      bit ok;
      clear_queues();
      n = 0;
      @(negedge clk);
      strobe_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         data_in = DW'(k);
         @(posedge clk);
         #1;
         exp_lvl = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
         checks++; if (fifo_level !== LVW'(exp_lvl)) begin errors++; $display("FAIL burst_level_%0d got=%0d exp=%0d", k, fifo_level, exp_lvl); end
         if (busy === 1'b1) n++;
         if (k <= DEPTH + 1) expect_sample(k);
      end
      strobe_in = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow got=%b exp=1", overflow); end
      for (int g = 0; g < 10 * SAMPLE_CYC && busy === 1'b1; g++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) n++;
      end
      checks++; if (n != 5 * SAMPLE_CYC) begin errors++; $display("FAIL burst_busy_len got=%0d exp=%0d", n, 5 * SAMPLE_CYC); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL burst_drain got=timeout exp=idle"); end
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL burst_byte_%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow_clear;
      int d;
      bit ok;
      pulse_clr();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_alone got=%b exp=0", overflow); end
      clear_queues();
      @(negedge clk);
      strobe_in = 1'b1;
      for (int k = 0; k < DEPTH + 2; k++) begin
         d = int'($urandom_range(0, (1 << DW) - 1));
         data_in = DW'(d);
         if (k == DEPTH + 1) clr_overflow = 1'b1;
         @(posedge clk);
         #1;
         if (k <= DEPTH) expect_sample(d);
      end
      strobe_in    = 1'b0;
      clr_overflow = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      pulse_clr();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_later got=%b exp=0", overflow); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got=timeout exp=idle"); end
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL ovf_byte_%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int s1;
      int s2;
      int n;
      bit ok;
      clear_queues();
      s1 = int'($urandom_range(0, (1 << DW) - 1));
      s2 = int'($urandom_range(0, (1 << DW) - 1));
      expect_sample(s1);
      expect_sample(s2);
      send(s1);
      n = 0;
      for (int cyc = 0; cyc < 4 * SAMPLE_CYC; cyc++) begin
         @(negedge clk);
         // Lands in the middle of byte B of the first sample.
         if (cyc == (FRAME_BITS + 2) * C) begin
            data_in   = DW'(s2);
            strobe_in = 1'b1;
         end
         @(posedge clk);
         #1;
         strobe_in = 1'b0;
         if (busy === 1'b1) n++;
         else if (n > 0) break;
      end
      checks++; if (n != 2 * SAMPLE_CYC) begin errors++; $display("FAIL b2b_busy_len got=%0d exp=%0d", n, 2 * SAMPLE_CYC); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_drain got=timeout exp=idle"); end
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_byte_%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_random;
      int len;
      int d;
      int exp_lvl;
      bit ok;
      for (int it = 0; it < 4; it++) begin
         pulse_clr();
         clear_queues();
         len = int'($urandom_range(1, DEPTH + 2));
         @(negedge clk);
         strobe_in = 1'b1;
         for (int k = 1; k <= len; k++) begin
            d = int'($urandom_range(0, (1 << DW) - 1));
            data_in = DW'(d);
            @(posedge clk);
            #1;
            if (k <= DEPTH + 1) expect_sample(d);
         end
         strobe_in = 1'b0;
         exp_lvl = (len == 1) ? 1 : ((len - 1 > DEPTH) ? DEPTH : len - 1);
         checks++; if (fifo_level !== LVW'(exp_lvl)) begin errors++; $display("FAIL rand%0d_level got=%0d exp=%0d", it, fifo_level, exp_lvl); end
         checks++; if (overflow !== (len > DEPTH + 1)) begin errors++; $display("FAIL rand%0d_overflow got=%b exp=%b", it, overflow, len > DEPTH + 1); end
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand%0d_drain got=timeout exp=idle", it); end
         checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
         foreach (exp_q[i]) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rand%0d_byte_%0d got=%h exp=%h", it, i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int viol;
      clear_queues();
      send(0);
      @(posedge clk);
      repeat (3 * C) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL midrst_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
      @(negedge clk);
      rst_n = 1'b1;
      viol = 0;
      repeat (30 * C) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      checks++; if (viol != 0)        begin errors++; $display("FAIL midrst_quiet got=%0d exp=0 active cycles", viol); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_residual got=%0d exp=0 bytes", rx_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow_clear();
      test_back_to_back();
      test_random();
      test_reset_mid();
      checks++; if (mon_err != 0) begin errors++; $display("FAIL frame_timing got=%0d exp=0 bad frames", mon_err); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
